syst_feeder: RTL and testbench

- Upstream operand feeder for the 4x4 output-stationary systolic array (syst_array).
- Buffers matrix A (row-major, drives the west inputs) and matrix B (drives the north inputs), then streams them with diagonal skew so that A[i][k] and B[k][j] meet in PE(i,j).
- Also emits the array clear pulse before each run and a completion pulse once the array has drained.

---
 rtl/syst_feeder.sv | 149 ++++++++++++++
 tb/tb_syst_feeder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syst_feeder.sv
// syst_feeder: holds A rows / B columns and streams them diagonally skewed into an NxN systolic array.
// Latency: start edge -> arr_clr next cycle, 3N-2 stream + DRAIN_CYCLES drain cycles, then a one-cycle done.
// Backpressure: loads accepted only while idle (load_ready); start ignored unless idle; feeds never stall.
module syst_feeder #(
  parameter int N            = 4,
  parameter int DW           = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic                 load_mat,
  input  logic [$clog2(N)-1:0] load_idx,
  input  logic [N*DW-1:0]      load_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 arr_clr,
  output logic [N*DW-1:0]      feed_w,
  output logic [N*DW-1:0]      feed_n,
  output logic                 done
);

  localparam int IW         = $clog2(N);
  localparam int STREAM_LEN = 3 * N - 2;
  localparam int CW         = $clog2(STREAM_LEN + DRAIN_CYCLES + 1);

  localparam logic [CW-1:0] STREAM_LAST = CW'(STREAM_LEN - 1);
  localparam logic [CW-1:0] DRAIN_LAST  = CW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // a_buf[r][c] = A[r][c]; b_buf[r][c] = B[r][c]
  logic [DW-1:0] a_buf [N][N];
  logic [DW-1:0] b_buf [N][N];

  // load_ready is registered high exactly while in IDLE, so it doubles as the load gate
  logic load_fire;
  assign load_fire = load_valid && load_ready;

  // Run sequencer: state, phase counter and the registered control outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      load_ready <= 1'b1;
      busy       <= 1'b0;
      arr_clr    <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_CLEAR;
            load_ready <= 1'b0;
            busy       <= 1'b1;
            arr_clr    <= 1'b1;
          end
        end
        S_CLEAR: begin
          state   <= S_STREAM;
          cnt     <= '0;
          arr_clr <= 1'b0;
        end
        S_STREAM: begin
          if (cnt == STREAM_LAST) begin
            cnt <= '0;
            if (DRAIN_CYCLES == 0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            cnt   <= '0;
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          done       <= 1'b0;
          load_ready <= 1'b1;
        end
        default: begin
          state      <= S_IDLE;
          cnt        <= '0;
          load_ready <= 1'b1;
          busy       <= 1'b0;
          arr_clr    <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

  // Operand store: an A load writes one row, a B load writes one column
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_buf[r][c] <= '0;
          b_buf[r][c] <= '0;
        end
      end
    end else if (load_fire) begin
      for (int e = 0; e < N; e++) begin
        if (!load_mat) begin
          a_buf[load_idx][e] <= load_data[e*DW +: DW];
        end else begin
          b_buf[e][load_idx] <= load_data[e*DW +: DW];
        end
      end
    end
  end

  // Skewed feed: lane i carries element k = t - i of row i (west) / column i (north)
  always_comb begin
    feed_w = '0;
    feed_n = '0;
    if (state == S_STREAM) begin
      for (int i = 0; i < N; i++) begin
        if ((cnt >= CW'(i)) && ((cnt - CW'(i)) < CW'(N))) begin
          feed_w[i*DW +: DW] = a_buf[i][IW'(cnt - CW'(i))];
          feed_n[i*DW +: DW] = b_buf[IW'(cnt - CW'(i))][i];
        end
      end
    end
  end

endmodule

// File: tb/tb_syst_feeder.sv
// tb_syst_feeder: timeline model of syst_feeder checked every cycle, plus literal pins.
// Drives inputs 1 time unit after the rising edge, samples outputs on the falling edge.
// Random phase mixes loads, starts and resets after the directed scenarios.
module tb_syst_feeder;

  localparam int N            = 4;
  localparam int DW           = 32;
  localparam int DRAIN_CYCLES = 4;
  localparam int W            = N * DW;
  localparam int SL           = 3 * N - 2;             // stream length
  localparam int H            = SL + DRAIN_CYCLES;     // feed cycles recorded per run
  localparam int DONE_AT      = 2 + SL + DRAIN_CYCLES; // period after start edge holding done

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic         load_mat = 1'b0;
  logic [1:0]   load_idx = '0;
  logic [W-1:0] load_data = '0;
  logic         start = 1'b0;
  logic         load_ready, busy, arr_clr, done;
  logic [W-1:0] feed_w, feed_n;

  syst_feeder #(.N(N), .DW(DW), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_mat(load_mat), .load_idx(load_idx), .load_data(load_data),
    .start(start), .busy(busy), .arr_clr(arr_clr),
    .feed_w(feed_w), .feed_n(feed_n), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: matrices plus "periods since the accepted start edge" (0 = idle)
  int            rc = 0;
  logic [DW-1:0] mA [N][N];
  logic [DW-1:0] mB [N][N];
  logic [W-1:0]  hw [H];
  logic [W-1:0]  hn [H];
  logic [DW-1:0] res [N][N];
  logic [W-1:0]  ew, en;
  int            tt;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model update on each sampled edge
  always @(posedge clk) begin
    if (rst) begin
      rc <= 0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          mA[r][c] <= '0;
          mB[r][c] <= '0;
        end
    end else if (rc == 0) begin
      if (load_valid) begin
        for (int e = 0; e < N; e++) begin
          if (!load_mat) mA[load_idx][e] <= load_data[e*DW +: DW];
          else           mB[e][load_idx] <= load_data[e*DW +: DW];
        end
      end
      if (start) rc <= 1;
    end else if (rc == DONE_AT) begin
      rc <= 0;
    end else begin
      rc <= rc + 1;
    end
  end

  // Emulate the output-stationary array from the recorded feeds and compare with A*B
  task automatic check_product();
    logic [DW-1:0] acc, ex;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = '0;
        for (int T = 0; T < H + N; T++) begin
          if (T - j >= 0 && T - j < H && T - i >= 0 && T - i < H)
            acc = acc + hw[T-j][i*DW +: DW] * hn[T-i][j*DW +: DW];
        end
        res[i][j] = acc;
        ex = '0;
        for (int k = 0; k < N; k++) ex = ex + mA[i][k] * mB[k][j];
        chk($sformatf("result%0d%0d", i, j), W'(acc), W'(ex));
      end
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      ew = '0;
      en = '0;
      if (rc >= 2 && rc < 2 + SL) begin
        tt = rc - 2;
        for (int i = 0; i < N; i++)
          if (tt - i >= 0 && tt - i < N) ew[i*DW +: DW] = mA[i][tt-i];
        for (int j = 0; j < N; j++)
          if (tt - j >= 0 && tt - j < N) en[j*DW +: DW] = mB[tt-j][j];
      end
      chk1("load_ready", load_ready, rc == 0);
      chk1("busy", busy, rc >= 1 && rc < DONE_AT);
      chk1("arr_clr", arr_clr, rc == 1);
      chk1("done", done, rc == DONE_AT);
      chk("feed_w", feed_w, ew);
      chk("feed_n", feed_n, en);
      if (rc >= 2 && rc < 2 + H) begin
        hw[rc-2] = feed_w;
        hn[rc-2] = feed_n;
      end
      if (rc == DONE_AT) check_product();
    end
  end

  task automatic drive(input int mode, input int c);
    if (mode == 3) begin
      load_valid = (c >= 2 && c <= 11);
      load_mat   = 1'b0;
      load_idx   = 2'd0;
      load_data  = '1;
    end
    if (mode == 4) start = (c == 6);
    if (mode == 5) rst = (c == 7);
  endtask

  task automatic pins(input int mode, input int c);
    if (mode == 2) begin
      if (c == 1) chk1("t2_clr", arr_clr, 1'b1);
      if (c == 2) begin
        chk1("t2_clr_off", arr_clr, 1'b0);
        chk("t2_t0_w", feed_w, W'(1));
        chk("t2_t0_n", feed_n, W'(1));
      end
      if (c == 5) begin
        chk("t2_t3_w", feed_w, '0);
        chk("t2_t3_n", feed_n, {32'd4, 32'd7, 32'd10, 32'd13});
      end
      if (c == 8) begin
        chk("t2_t6_w", feed_w, {32'd1, 96'd0});
        chk("t2_t6_n", feed_n, {32'd16, 96'd0});
      end
      if (c == 11 || c == 12) begin
        chk("t2_tail_w", feed_w, '0);
        chk("t2_tail_n", feed_n, '0);
      end
    end
    if (mode == 3 && c == 5) chk1("t3_load_ready", load_ready, 1'b0);
    if (mode == 4 && c == 4) chk("t4_t2_n", feed_n, {32'd0, 32'd100, 32'd6, 32'd9});
    if (mode == 5 && c == 8) begin
      chk("t5_abort_w", feed_w, '0);
      chk("t5_abort_n", feed_n, '0);
      chk1("t5_abort_ready", load_ready, 1'b1);
      chk1("t5_abort_busy", busy, 1'b0);
    end
    if (mode == 6 && c == 5) begin
      chk("t6_zero_w", feed_w, '0);
      chk("t6_zero_n", feed_n, '0);
    end
  endtask

  // Runs n periods starting at period 1 after a start edge; reports done latency/count and busy cycles
  task automatic run_window(input int mode, input int n, output int lat, output int nd, output int nb);
    lat = -1;
    nd  = 0;
    nb  = 0;
    for (int c = 1; c <= n; c++) begin
      drive(mode, c);
      @(negedge clk);
      pins(mode, c);
      if (done === 1'b1) begin
        nd++;
        if (lat < 0) lat = c;
      end
      if (busy === 1'b1) nb++;
      @(posedge clk);
      #1;
    end
    load_valid = 1'b0;
    start      = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic do_load(input logic mat, input logic [1:0] idx, input logic [W-1:0] d);
    load_valid = 1'b1;
    load_mat   = mat;
    load_idx   = idx;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int lat, nd, nb;
    logic [W-1:0] v;

    repeat (2) tick();
    chk_en = 1'b1;
    rst    = 1'b0;
    repeat (5) tick();
    chk1("idle_load_ready", load_ready, 1'b1);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_done", done, 1'b0);
    chk1("idle_arr_clr", arr_clr, 1'b0);
    chk("idle_feed_w", feed_w, '0);
    chk("idle_feed_n", feed_n, '0);

    // A = identity, B[r][c] = 4r+c+1
    for (int r = 0; r < N; r++) begin
      v = '0;
      v[r*DW +: DW] = 32'd1;
      do_load(1'b0, 2'(r), v);
    end
    for (int c = 0; c < N; c++) begin
      v = '0;
      for (int e = 0; e < N; e++) v[e*DW +: DW] = 32'(4 * e + c + 1);
      do_load(1'b1, 2'(c), v);
    end
    pulse_start();
    run_window(2, 30, lat, nd, nb);
    chk_int("t2_done_latency", lat, 16);
    chk_int("t2_done_count", nd, 1);
    chk_int("t2_busy_cycles", nb, 15);
    chk("t2_result5", W'(res[1][1]), W'(6));
    chk("t2_result15", W'(res[3][3]), W'(16));

    // Load held during the stream must be refused
    pulse_start();
    run_window(3, 30, lat, nd, nb);
    chk_int("t3_done_count", nd, 1);
    chk("t3_result5", W'(res[1][1]), W'(6));
    chk("t3_result3", W'(res[0][3]), W'(4));

    // Start together with a B column-2 load; second start mid-run
    v = '0;
    for (int e = 0; e < N; e++) v[e*DW +: DW] = 32'(100 + e);
    load_valid = 1'b1;
    load_mat   = 1'b1;
    load_idx   = 2'd2;
    load_data  = v;
    start      = 1'b1;
    tick();
    load_valid = 1'b0;
    start      = 1'b0;
    run_window(4, 30, lat, nd, nb);
    chk_int("t4_done_count", nd, 1);
    chk_int("t4_done_latency", lat, 16);
    chk("t4_result10", W'(res[2][2]), W'(102));

    // Reset mid-run, then a run on cleared buffers
    pulse_start();
    run_window(5, 30, lat, nd, nb);
    chk_int("t5_done_count", nd, 0);
    pulse_start();
    run_window(6, 30, lat, nd, nb);
    chk_int("t6_done_latency", lat, 16);
    chk_int("t6_done_count", nd, 1);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      rst        = ($urandom_range(0, 99) == 0);
      load_valid = 1'($urandom_range(0, 1));
      load_mat   = 1'($urandom_range(0, 1));
      load_idx   = 2'($urandom_range(0, N - 1));
      for (int e = 0; e < N; e++) v[e*DW +: DW] = $urandom;
      load_data  = v;
      start      = ($urandom_range(0, 7) == 0);
      tick();
    end
    rst        = 1'b0;
    load_valid = 1'b0;
    start      = 1'b0;
    repeat (25) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
